// File: rtl/user_edge_scan_ctrl.sv
// user_edge_scan_ctrl: OBI-programmed scan controller that walks a 3x3
// window over an image in ROM, feeds the Sobel magnitude engine and
// accumulates an edge count and the peak magnitude.

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [0:0]  rid;
  } obi_rsp_t;

endpackage

module user_edge_scan_ctrl #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  input  logic        rom_valid_i,
  output logic        win_valid_o,
  input  logic        win_ready_i,
  output logic [71:0] win_pix_o,
  input  logic        mag_valid_i,
  input  logic [15:0] mag_i,
  output logic        irq_o
);

  localparam int unsigned DataW = ObiCfg.DataWidth;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_MAG, DONE} state_e;

  state_e state_q, state_d;

  // Software-visible configuration (takes effect at the next start)
  logic [31:0] baseCfg_q;
  logic [7:0]  widthCfg_q, heightCfg_q;
  logic [15:0] threshCfg_q;

  // Live copies latched at start, plus scan position and results
  logic [31:0]     base_q, base_d;
  logic [7:0]      width_q, width_d, height_q, height_d;
  logic [15:0]     thresh_q, thresh_d;
  logic [7:0]      x_q, x_d, y_q, y_d;
  logic [3:0]      k_q, k_d;
  logic [8:0][7:0] pix_q, pix_d;
  logic [15:0]     edgeCnt_q, edgeCnt_d, maxMag_q, maxMag_d;
  logic            cfgErr_q, cfgErr_d;
  logic            irq_q, irq_d;

  // Bus response registers
  logic             rvalid_q, err_q, rid_q;
  logic [DataW-1:0] rdata_q, readVal;

  logic [2:0] regIdx;
  logic       busRd, busWr, badAcc, startReq, abortReq;
  logic       busy, done;
  logic [1:0] kRow, kCol;
  logic       unusedBits;

  assign busy = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT_MAG);
  assign done = (state_q == DONE);

  assign unusedBits = ^{obi_req_i.be, obi_req_i.addr[31:5], obi_req_i.addr[1:0]};

  // Decode the bus access, flag illegal ones and build read data
  always_comb begin
    regIdx   = obi_req_i.addr[4:2];
    busRd    = obi_req_i.req && !obi_req_i.we;
    busWr    = obi_req_i.req && obi_req_i.we;
    badAcc   = (busRd && regIdx == 3'd0) ||
               (busWr && (regIdx == 3'd4 || regIdx == 3'd5 || regIdx == 3'd6)) ||
               (obi_req_i.req && regIdx == 3'd7);
    startReq = busWr && regIdx == 3'd0 && obi_req_i.wdata[0];
    abortReq = busWr && regIdx == 3'd0 && obi_req_i.wdata[1];
    readVal  = '0;
    case (regIdx)
      3'd1:    readVal = baseCfg_q;
      3'd2:    readVal = {16'b0, heightCfg_q, widthCfg_q};
      3'd3:    readVal = {16'b0, threshCfg_q};
      3'd4:    readVal = {29'b0, cfgErr_q, done, busy};
      3'd5:    readVal = {16'b0, edgeCnt_q};
      3'd6:    readVal = {16'b0, maxMag_q};
      default: readVal = '0;
    endcase
  end

  // Register the bus response one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= 1'b0;
    end else begin
      rvalid_q <= obi_req_i.req;
      err_q    <= obi_req_i.req && badAcc;
      rdata_q  <= (busRd && !badAcc) ? readVal : '0;
      rid_q    <= obi_req_i.aid;
    end
  end

  // Drive the response struct; grant is immediate
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
  end

  // Configuration registers, writable at any time
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baseCfg_q   <= '0;
      widthCfg_q  <= '0;
      heightCfg_q <= '0;
      threshCfg_q <= '0;
    end else if (busWr) begin
      if (regIdx == 3'd1) baseCfg_q <= obi_req_i.wdata;
      if (regIdx == 3'd2) begin
        widthCfg_q  <= obi_req_i.wdata[7:0];
        heightCfg_q <= obi_req_i.wdata[15:8];
      end
      if (regIdx == 3'd3) threshCfg_q <= obi_req_i.wdata[15:0];
    end
  end

  // Split the pixel index into window row and column offsets
  always_comb begin
    kRow = 2'd0;
    kCol = 2'd0;
    case (k_q)
      4'd1: kCol = 2'd1;
      4'd2: kCol = 2'd2;
      4'd3: kRow = 2'd1;
      4'd4: begin kRow = 2'd1; kCol = 2'd1; end
      4'd5: begin kRow = 2'd1; kCol = 2'd2; end
      4'd6: kRow = 2'd2;
      4'd7: begin kRow = 2'd2; kCol = 2'd1; end
      4'd8: begin kRow = 2'd2; kCol = 2'd2; end
      default: begin kRow = 2'd0; kCol = 2'd0; end
    endcase
  end

  assign rom_req_o   = (state_q == FETCH);
  assign rom_addr_o  = base_q + ({24'b0, y_q} + {30'b0, kRow}) * {24'b0, width_q}
                       + {24'b0, x_q} + {30'b0, kCol};
  assign win_valid_o = (state_q == ISSUE);
  assign win_pix_o   = pix_q;
  assign irq_o       = irq_q;

  // Next-state logic for the scan FSM, counters and results
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    width_d   = width_q;
    height_d  = height_q;
    thresh_d  = thresh_q;
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    pix_d     = pix_q;
    edgeCnt_d = edgeCnt_q;
    maxMag_d  = maxMag_q;
    cfgErr_d  = cfgErr_q;
    irq_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (startReq) begin
          cfgErr_d  = 1'b0;
          edgeCnt_d = '0;
          maxMag_d  = '0;
          base_d    = baseCfg_q;
          width_d   = widthCfg_q;
          height_d  = heightCfg_q;
          thresh_d  = threshCfg_q;
          if (widthCfg_q < 8'd3 || heightCfg_q < 8'd3) begin
            cfgErr_d = 1'b1;
            irq_d    = 1'b1;
            state_d  = DONE;
          end else begin
            x_d     = '0;
            y_d     = '0;
            k_d     = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (abortReq) begin
          state_d = IDLE;
        end else if (rom_valid_i) begin
          pix_d[k_q] = rom_data_i;
          if (k_q == 4'd8) state_d = ISSUE;
          else             k_d = k_q + 4'd1;
        end
      end
      ISSUE: begin
        if (abortReq)         state_d = IDLE;
        else if (win_ready_i) state_d = WAIT_MAG;
      end
      WAIT_MAG: begin
        if (abortReq) begin
          state_d = IDLE;
        end else if (mag_valid_i) begin
          if (mag_i > thresh_q && edgeCnt_q != 16'hFFFF) edgeCnt_d = edgeCnt_q + 16'd1;
          if (mag_i > maxMag_q) maxMag_d = mag_i;
          k_d = '0;
          if (x_q == width_q - 8'd3) begin
            x_d = '0;
            if (y_q == height_q - 8'd3) begin
              state_d = DONE;
              irq_d   = 1'b1;
            end else begin
              y_d     = y_q + 8'd1;
              state_d = FETCH;
            end
          end else begin
            x_d     = x_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      width_q   <= '0;
      height_q  <= '0;
      thresh_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      pix_q     <= '0;
      edgeCnt_q <= '0;
      maxMag_q  <= '0;
      cfgErr_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      width_q   <= width_d;
      height_q  <= height_d;
      thresh_q  <= thresh_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      pix_q     <= pix_d;
      edgeCnt_q <= edgeCnt_d;
      maxMag_q  <= maxMag_d;
      cfgErr_q  <= cfgErr_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_user_edge_scan_ctrl.sv
// tb_user_edge_scan_ctrl: directed and randomized scans of user_edge_scan_ctrl
// against a window-level reference model of addresses, pixels and results.

module tb_user_edge_scan_ctrl;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  obi_pkg::obi_req_t obiReq;
  obi_pkg::obi_rsp_t obiRsp;
  logic              romReq, romValid;
  logic [31:0]       romAddr;
  logic [7:0]        romData;
  logic              winValid, winReady;
  logic [71:0]       winPix;
  logic              magValid;
  logic [15:0]       mag;
  logic              irq;

  user_edge_scan_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .obi_req_i   (obiReq),
    .obi_rsp_o   (obiRsp),
    .rom_req_o   (romReq),
    .rom_addr_o  (romAddr),
    .rom_data_i  (romData),
    .rom_valid_i (romValid),
    .win_valid_o (winValid),
    .win_ready_i (winReady),
    .win_pix_o   (winPix),
    .mag_valid_i (magValid),
    .mag_i       (mag),
    .irq_o       (irq)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int irqCount = 0, romReqCycles = 0, winAccepted = 0;
  int irqSnap, winSnap, romSnap;

  // Scan model state
  logic [31:0] mBase;
  int          mW, mH, mThr, curWin;
  int          magQ[$];

  // Passive monitors counting irq pulses, ROM request cycles and accepted windows
  always @(negedge clk_i) begin
    if (irq === 1'b1) irqCount++;
    if (romReq === 1'b1) romReqCycles++;
    if (winValid === 1'b1 && winReady === 1'b1) winAccepted++;
  end

  // Time limit so the run always ends
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] romByte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] addrOf(input int wi, input int k);
    int x, y;
    x = wi % (mW - 2);
    y = wi / (mW - 2);
    return mBase + 32'((y + k / 3) * mW + x + k % 3);
  endfunction

  function automatic int expEdges(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (magQ[i] > mThr && c < 65535) c++;
    return c;
  endfunction

  function automatic int expMax(input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (magQ[i] > m) m = magQ[i];
    return m;
  endfunction

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic expErr, input string tag);
    logic id;
    id = 1'($urandom);
    obiReq       = '0;
    obiReq.req   = 1'b1;
    obiReq.we    = 1'b1;
    obiReq.be    = 4'hF;
    obiReq.addr  = addr;
    obiReq.wdata = data;
    obiReq.aid   = id;
    #1;
    check({tag, ".gnt"}, obiRsp.gnt, 1);
    @(posedge clk_i);
    #1;
    obiReq = '0;
    check({tag, ".rvalid"}, obiRsp.rvalid, 1);
    check({tag, ".err"}, obiRsp.err, expErr);
    check({tag, ".rid"}, obiRsp.rid, id);
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [31:0] expData,
                         input logic expErr, input string tag);
    logic id;
    id = 1'($urandom);
    obiReq      = '0;
    obiReq.req  = 1'b1;
    obiReq.addr = addr;
    obiReq.aid  = id;
    @(posedge clk_i);
    #1;
    obiReq = '0;
    check({tag, ".rvalid"}, obiRsp.rvalid, 1);
    check({tag, ".err"}, obiRsp.err, expErr);
    check({tag, ".rid"}, obiRsp.rid, id);
    if (!expErr) check({tag, ".rdata"}, obiRsp.rdata, expData);
  endtask

  task automatic applyStimulusCfg(input logic [31:0] base, input int w, input int h, input int thr);
    mBase = base;
    mW    = w;
    mH    = h;
    mThr  = thr;
    busWrite(32'h04, base, 1'b0, "wrBase");
    busWrite(32'h08, 32'((h << 8) | w), 1'b0, "wrDim");
    busWrite(32'h0C, 32'(thr), 1'b0, "wrThresh");
    busRead(32'h08, 32'((h << 8) | w), 1'b0, "rdDim");
  endtask

  task automatic startScan(input string tag);
    curWin  = 0;
    irqSnap = irqCount;
    winSnap = winAccepted;
    romSnap = romReqCycles;
    busWrite(32'h00, 32'h1, 1'b0, tag);
  endtask

  task automatic fetchPixels(input int wi, input int nPix, input bit randDelay, input int romDelay);
    logic [31:0] a;
    int d;
    for (int k = 0; k < nPix; k++) begin
      a = addrOf(wi, k);
      for (int t = 0; t < 10 && romReq !== 1'b1; t++) step();
      d = randDelay ? int'($urandom_range(2, 0)) : romDelay;
      for (int j = 0; j < d; j++) begin
        check("romAddrHold", romAddr, 72'(a));
        step();
      end
      check("romReq", romReq, 1);
      check("romAddr", romAddr, 72'(a));
      romValid = 1'b1;
      romData  = romByte(a);
      step();
      romValid = 1'b0;
      romData  = 8'($urandom);
    end
  endtask

  task automatic runWindows(input int nWin, input bit randDelay, input int romDelay, input int readyDelay);
    logic [71:0] p;
    int d;
    for (int n = 0; n < nWin; n++) begin
      fetchPixels(curWin, 9, randDelay, romDelay);
      for (int k = 0; k < 9; k++) p[k*8 +: 8] = romByte(addrOf(curWin, k));
      for (int t = 0; t < 5 && winValid !== 1'b1; t++) step();
      check("winValid", winValid, 1);
      check("winPix", winPix, p);
      d = randDelay ? int'($urandom_range(3, 0)) : readyDelay;
      for (int j = 0; j < d; j++) begin
        step();
        check("winValidHold", winValid, 1);
        check("winPixHold", winPix, p);
      end
      winReady = 1'b1;
      step();
      winReady = 1'b0;
      check("winValidDrop", winValid, 0);
      d = randDelay ? int'($urandom_range(2, 0)) : 0;
      for (int j = 0; j < d; j++) step();
      magValid = 1'b1;
      mag      = 16'(magQ[curWin]);
      step();
      magValid = 1'b0;
      mag      = 16'($urandom);
      curWin++;
    end
  endtask

  task automatic checkOutput(input int nWin, input string tag);
    check({tag, ".irqPulse"}, irq, 1);
    step();
    check({tag, ".irqLow"}, irq, 0);
    busRead(32'h10, 32'h2, 1'b0, {tag, ".status"});
    busRead(32'h14, 32'(expEdges(nWin)), 1'b0, {tag, ".edgeCnt"});
    busRead(32'h18, 32'(expMax(nWin)), 1'b0, {tag, ".maxMag"});
    check({tag, ".irqCount"}, 72'(irqCount - irqSnap), 1);
    check({tag, ".windows"}, 72'(winAccepted - winSnap), 72'(nWin));
  endtask

  initial begin
    rst_ni   = 1'b0;
    obiReq   = '0;
    romValid = 1'b0;
    romData  = '0;
    winReady = 1'b0;
    magValid = 1'b0;
    mag      = '0;
    step();
    step();
    check("rst.romReq", romReq, 0);
    check("rst.romAddr", romAddr, 0);
    check("rst.winValid", winValid, 0);
    check("rst.winPix", winPix, 0);
    check("rst.irq", irq, 0);
    check("rst.rvalid", obiRsp.rvalid, 0);
    check("rst.err", obiRsp.err, 0);
    check("rst.rdata", obiRsp.rdata, 0);
    rst_ni = 1'b1;
    step();
    busRead(32'h04, 0, 1'b0, "rst.base");
    busRead(32'h08, 0, 1'b0, "rst.dim");
    busRead(32'h0C, 0, 1'b0, "rst.thresh");
    busRead(32'h10, 0, 1'b0, "rst.status");
    busRead(32'h14, 0, 1'b0, "rst.edgeCnt");
    busRead(32'h18, 0, 1'b0, "rst.maxMag");

    // 4x4 image, zero-delay handshakes
    applyStimulusCfg(32'h100, 4, 4, 10);
    magQ = '{5, 11, 10, 200};
    startScan("start4x4");
    busRead(32'h10, 32'h1, 1'b0, "busyAfterStart");
    runWindows(4, 1'b0, 0, 0);
    checkOutput(4, "scan4x4");

    // Degenerate dimensions: no ROM traffic, cfg_err and done
    applyStimulusCfg(32'h100, 2, 5, 10);
    startScan("startBadDim");
    check("badDim.irqPulse", irq, 1);
    step();
    check("badDim.irqLow", irq, 0);
    busRead(32'h10, 32'h6, 1'b0, "badDim.status");
    check("badDim.romReqCycles", 72'(romReqCycles - romSnap), 0);
    check("badDim.irqCount", 72'(irqCount - irqSnap), 1);

    // Same 4x4 image with slow ROM and slow engine
    applyStimulusCfg(32'h100, 4, 4, 10);
    magQ = '{5, 11, 10, 200};
    startScan("startSlow");
    runWindows(4, 1'b0, 3, 5);
    checkOutput(4, "scanSlow");

    // Abort during the fetch of the second window
    applyStimulusCfg(32'h200, 4, 4, 10);
    magQ = '{50, 300, 300, 300};
    startScan("startAbortF");
    runWindows(1, 1'b0, 0, 0);
    fetchPixels(1, 3, 1'b0, 0);
    irqSnap = irqCount;
    busWrite(32'h00, 32'h2, 1'b0, "abortFetch");
    check("abortF.romReqDrop", romReq, 0);
    romValid = 1'b1;
    romData  = 8'hFF;
    step();
    romValid = 1'b0;
    check("abortF.romReqIdle", romReq, 0);
    busRead(32'h10, 32'h0, 1'b0, "abortF.status");
    busRead(32'h14, 32'd1, 1'b0, "abortF.edgeCnt");
    busRead(32'h18, 32'd50, 1'b0, "abortF.maxMag");
    check("abortF.noIrq", 72'(irqCount - irqSnap), 0);

    // Abort while waiting for the magnitude; a late result is dropped
    startScan("startAbortM");
    fetchPixels(0, 9, 1'b0, 0);
    check("abortM.winValid", winValid, 1);
    winReady = 1'b1;
    step();
    winReady = 1'b0;
    busWrite(32'h00, 32'h2, 1'b0, "abortMag");
    magValid = 1'b1;
    mag      = 16'hFFFF;
    step();
    magValid = 1'b0;
    busRead(32'h10, 32'h0, 1'b0, "abortM.status");
    busRead(32'h14, 32'd0, 1'b0, "abortM.edgeCnt");
    busRead(32'h18, 32'd0, 1'b0, "abortM.maxMag");
    check("abortM.noIrq", 72'(irqCount - irqSnap), 0);

    // Start while busy, illegal accesses and a DIM write mid-scan
    applyStimulusCfg($urandom, 4, 4, 10);
    magQ = '{20, 5, 15, 3};
    startScan("startBusy");
    runWindows(1, 1'b0, 0, 0);
    busWrite(32'h00, 32'h1, 1'b0, "startWhileBusy");
    busRead(32'h00, 0, 1'b1, "readCtrl");
    busWrite(32'h14, 32'h1234, 1'b1, "writeEdgeCnt");
    busRead(32'h1C, 0, 1'b1, "read1C");
    busWrite(32'h08, 32'h0303, 1'b0, "dimWhileBusy");
    runWindows(3, 1'b0, 0, 0);
    checkOutput(4, "scanBusy");
    busRead(32'h08, 32'h0303, 1'b0, "dimReadback");

    // Randomized images, thresholds, magnitudes and handshake delays
    for (int it = 0; it < 3; it++) begin
      applyStimulusCfg($urandom, int'($urandom_range(6, 3)), int'($urandom_range(5, 3)),
                       int'($urandom_range(300, 0)));
      magQ.delete();
      for (int i = 0; i < (mW - 2) * (mH - 2); i++) magQ.push_back(int'($urandom_range(400, 0)));
      startScan("startRand");
      runWindows((mW - 2) * (mH - 2), 1'b1, 0, 0);
      checkOutput((mW - 2) * (mH - 2), "scanRand");
    end

    // Widest image, single window row
    applyStimulusCfg(32'h1000, 255, 3, 0);
    magQ.delete();
    for (int i = 0; i < 253; i++) magQ.push_back(65535);
    startScan("startWide");
    runWindows(253, 1'b0, 0, 0);
    checkOutput(253, "scanWide");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
